// File: rtl/digit_frame_capture_if.sv
// digit_frame_capture_if
//   Bundles the pixel stream and recognizer read port of digit_frame_capture.
//   Pixel stream : pix_valid, pix_sof, pix_data (to block), pix_ready (from block)
//   Read side    : rd_addr, frame_ack (to block), frame_valid, rd_data,
//                  err_short (from block)
//   slave  : the capture block
//   master : the upstream source / recognizer driving the block
interface digit_frame_capture_if;
  logic       pix_valid;
  logic       pix_sof;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       frame_valid;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ack;
  logic       err_short;

  modport slave (
    input  pix_valid, pix_sof, pix_data, rd_addr, frame_ack,
    output pix_ready, frame_valid, rd_data, err_short
  );

  modport master (
    output pix_valid, pix_sof, pix_data, rd_addr, frame_ack,
    input  pix_ready, frame_valid, rd_data, err_short
  );
endinterface

// File: rtl/digit_frame_capture.sv
// digit_frame_capture
//   Captures raster-order grayscale frames (IMG_W x IMG_H), binarizes each
//   pixel against THRESH (optionally inverted) and stores frames in a
//   two-bank ping-pong buffer. A completed bank stays readable through a
//   registered read port until frame_ack releases it.
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : digit_frame_capture_if.slave (pixel stream + read port)
module digit_frame_capture #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter logic [7:0]  THRESH = 8'd128,
  parameter bit          INVERT = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  digit_frame_capture_if.slave bus
);

  localparam int unsigned N    = IMG_W * IMG_H;
  localparam logic [9:0]  LAST = 10'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_e;

  state_e     state_q, state_d;
  logic [9:0] idx_q, idx_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic       err_q, err_d;
  logic [7:0] rd_data_q;

  logic [7:0] mem [2][N];

  logic       ready;
  logic       accept;
  logic       ack_take;
  logic       we;
  logic [9:0] waddr;
  logic [7:0] bin_pix;

  assign ready    = !rst && (state_q != STALL);
  assign accept   = bus.pix_valid && ready;
  assign ack_take = bus.frame_ack && full_q[rd_bank_q];
  assign bin_pix  = ((bus.pix_data >= THRESH) ? 8'hFF : 8'h00) ^ {8{INVERT}};

  // The ack is applied to full_d before the completion logic looks at the
  // other bank, so a bank released in the same cycle a frame completes is
  // immediately available and no STALL is entered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    err_d     = 1'b0;
    we        = 1'b0;
    waddr     = idx_q;

    if (ack_take) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    unique case (state_q)
      IDLE: begin
        if (accept && bus.pix_sof) begin
          we      = 1'b1;
          waddr   = '0;
          idx_d   = 10'd1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          we = 1'b1;
          if (bus.pix_sof) begin
            // Restart of a short frame: same bank, beat lands at index 0.
            err_d = 1'b1;
            waddr = '0;
            idx_d = 10'd1;
          end else if (idx_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            idx_d             = '0;
            state_d           = full_d[~wr_bank_q] ? STALL : IDLE;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end
      STALL: begin
        if (!full_q[wr_bank_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank_q][waddr] <= bin_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (bus.rd_addr <= LAST) begin
      rd_data_q <= mem[rd_bank_q][bus.rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign bus.pix_ready   = ready;
  assign bus.frame_valid = !rst && full_q[rd_bank_q];
  assign bus.rd_data     = rd_data_q;
  assign bus.err_short   = err_q;

endmodule
